// File: rtl/imem_responder_pkg.sv
// Shared constants, state encoding and address helper for the instruction-memory responder.
package imem_responder_pkg;

    localparam int WORD_LEN = 32;
    localparam logic [WORD_LEN-1:0] START_ADDR = 32'h0000_0000;
    localparam logic [WORD_LEN-1:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IM_IDLE = 2'd0,
        IM_WAIT = 2'd1,
        IM_RESP = 2'd2
    } imem_state_e;

    // Word offset of a byte address relative to the array base; low byte-lane bits drop out.
    function automatic logic [WORD_LEN-1:0] word_offset(input logic [WORD_LEN-1:0] addr,
                                                        input logic [WORD_LEN-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-port bundle between the core (master) and the instruction memory (slave).
interface imem_responder_if;

    logic                                     req_valid;
    logic                                     req_ready;
    logic [imem_responder_pkg::WORD_LEN-1:0]  req_addr;
    logic                                     rsp_valid;
    logic                                     rsp_ready;
    logic [imem_responder_pkg::WORD_LEN-1:0]  rsp_inst;
    logic                                     rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );

endinterface

// File: rtl/imem_array.sv
// DEPTH x WIDTH instruction store: one synchronous read port, one synchronous write port.
// A read and write to the same word in one cycle returns the old contents.
module imem_array #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch, waits LAT cycles, holds the word until consumed.
// Define IMEM_ERR_EN to flag misaligned or out-of-range fetches with rsp_err and a NOP instruction.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int                  DEPTH     = 4096,
    parameter int                  LAT       = 2,
    parameter logic [WORD_LEN-1:0] BASE_ADDR = START_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    imem_responder_if.slave          bus,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [WORD_LEN-1:0]      ld_data,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    imem_state_e         state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d, rd_idx, req_idx;
    logic [WORD_LEN-1:0] inst_q, inst_d, arr_rdata;
    logic                rdy_en_q, rdy_en_d;
    logic                rd_pend_q, rd_pend_d;
    logic                accept, rd_fire, rd_fault, rd_en;

    assign req_idx  = AW'(word_offset(bus.req_addr, BASE_ADDR));
    assign accept   = (state_q == IM_IDLE) && rdy_en_q && bus.req_valid;
    assign rd_en    = rd_fire && !rd_fault;
    assign rdy_en_d = 1'b1;

    // With zero wait states the array is read in the accept cycle straight from the request address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_idx  = idx_q;
        rd_fire = 1'b0;
        case (state_q)
            IM_IDLE: begin
                if (accept) begin
                    idx_d = req_idx;
                    cnt_d = 4'(LAT);
                    if (LAT > 0) begin
                        state_d = IM_WAIT;
                    end else begin
                        state_d = IM_RESP;
                        rd_fire = 1'b1;
                        rd_idx  = req_idx;
                    end
                end
            end
            IM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    rd_fire = 1'b1;
                    state_d = IM_RESP;
                end
            end
            IM_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IM_IDLE;
                end
            end
            default: state_d = IM_IDLE;
        endcase
    end

    // Array data shows up one cycle after the read; it is folded into the holding register then.
    always_comb begin
        rd_pend_d = rd_en;
        inst_d    = rd_pend_q ? arr_rdata : inst_q;
        if (rd_fire && rd_fault) begin
            inst_d = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IM_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            inst_q    <= '0;
            rdy_en_q  <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            inst_q    <= inst_d;
            rdy_en_q  <= rdy_en_d;
            rd_pend_q <= rd_pend_d;
        end
    end

`ifdef IMEM_ERR_EN
    logic [WORD_LEN-1:0] req_word;
    logic                fault_now, fault_q, fault_d, err_q, err_d;

    assign req_word  = word_offset(bus.req_addr, BASE_ADDR);
    assign fault_now = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                       (req_word >= WORD_LEN'(DEPTH));
    assign fault_d   = accept ? fault_now : fault_q;
    assign rd_fault  = (state_q == IM_IDLE) ? fault_now : fault_q;
    assign err_d     = rd_fire ? rd_fault : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fault_q <= fault_d;
            err_q   <= err_d;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign rd_fault    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_LEN)
    ) u_array (
        .clk   (clk),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (arr_rdata),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data)
    );

    assign bus.req_ready = (state_q == IM_IDLE) && rdy_en_q;
    assign bus.rsp_valid = (state_q == IM_RESP);
    assign bus.rsp_inst  = rd_pend_q ? arr_rdata : inst_q;
    assign busy          = (state_q != IM_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LAT=2 and a LAT=0 instance share one loader port and are checked
// every cycle against a transaction-level model, plus directed hand-computed expectations.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic        busy_a, busy_b;
    int          total = 0;
    int          bad = 0;

    imem_responder_if ifa();
    imem_responder_if ifb();

    imem_responder #(.DEPTH(DEPTH), .LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy_a)
    );

    imem_responder #(.DEPTH(DEPTH), .LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Reference model: memory image plus, per instance, "a fetch is outstanding, N cycles old".
    logic [31:0] mem_m [DEPTH];
    bit          live_m;
    bit          out_m  [2];
    int          age_m  [2];
    logic [31:0] addr_m [2];
    logic [31:0] data_m [2];
    bit          err_m  [2];

    function automatic int latOf(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic void resolve(input logic [31:0] addr, output logic [31:0] d, output bit e);
        int unsigned widx;
        widx = (addr / 4) % DEPTH;
`ifdef IMEM_ERR_EN
        e = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
`else
        e = 1'b0;
`endif
        d = e ? 32'h0000_0013 : mem_m[widx[11:0]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_m <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                out_m[k] <= 1'b0;
                age_m[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic        v, rr;
                logic [31:0] a, d;
                bit          e;
                v  = (k == 0) ? ifa.req_valid : ifb.req_valid;
                a  = (k == 0) ? ifa.req_addr  : ifb.req_addr;
                rr = (k == 0) ? ifa.rsp_ready : ifb.rsp_ready;
                if (out_m[k] && (age_m[k] >= latOf(k) + 1) && rr) begin
                    out_m[k] <= 1'b0;
                end else if (out_m[k]) begin
                    age_m[k] <= age_m[k] + 1;
                    if (age_m[k] == latOf(k)) begin
                        resolve(addr_m[k], d, e);
                        data_m[k] <= d;
                        err_m[k]  <= e;
                    end
                end else if (live_m && v) begin
                    out_m[k]  <= 1'b1;
                    age_m[k]  <= 1;
                    addr_m[k] <= a;
                    if (latOf(k) == 0) begin
                        resolve(a, d, e);
                        data_m[k] <= d;
                        err_m[k]  <= e;
                    end
                end
            end
            if (ld_we) begin
                mem_m[ld_addr] <= ld_data;
            end
            live_m <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compareDut(input string tag, input int k, input logic rdy, input logic vld,
                              input logic [31:0] inst, input logic err, input logic bsy);
        bit ev;
        ev = out_m[k] && (age_m[k] >= latOf(k) + 1);
        checkOutput({tag, ".req_ready"}, 32'(rdy), 32'(live_m && !out_m[k]));
        checkOutput({tag, ".rsp_valid"}, 32'(vld), 32'(ev));
        checkOutput({tag, ".busy"}, 32'(bsy), 32'(out_m[k]));
        if (ev) begin
            checkOutput({tag, ".rsp_inst"}, inst, data_m[k]);
            checkOutput({tag, ".rsp_err"}, 32'(err), 32'(err_m[k]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            compareDut("A", 0, ifa.req_ready, ifa.rsp_valid, ifa.rsp_inst, ifa.rsp_err, busy_a);
            compareDut("B", 1, ifb.req_ready, ifb.rsp_valid, ifb.rsp_inst, ifb.rsp_err, busy_b);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one cycle's worth of inputs, then advance to the next cycle's drive point.
    task automatic applyStimulus(input logic va, input logic [31:0] aa, input logic ra,
                                 input logic vb, input logic [31:0] ab, input logic rb,
                                 input logic we, input logic [11:0] widx, input logic [31:0] wdata);
        ifa.req_valid = va; ifa.req_addr = aa; ifa.rsp_ready = ra;
        ifb.req_valid = vb; ifb.req_addr = ab; ifb.rsp_ready = rb;
        ld_we = we; ld_addr = widx; ld_data = wdata;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic load(input logic [11:0] widx, input logic [31:0] wdata);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, widx, wdata);
    endtask

    task automatic fetchA(input logic [31:0] addr, input logic rr);
        applyStimulus(1'b1, addr, rr, 1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic fetchB(input logic [31:0] addr);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, addr, 1'b1, 1'b0, 12'h0, 32'h0);
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_addr = 32'h0; ifa.rsp_ready = 1'b1;
        ifb.req_valid = 1'b0; ifb.req_addr = 32'h0; ifb.rsp_ready = 1'b1;
        ld_we = 1'b0; ld_addr = 12'h0; ld_data = 32'h0;

        // Reset state, then ready one cycle after release.
        tick();
        checkOutput("rst.A.req_ready", 32'(ifa.req_ready), 32'd0);
        checkOutput("rst.A.rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        checkOutput("rst.A.busy", 32'(busy_a), 32'd0);
        checkOutput("rst.A.rsp_inst", ifa.rsp_inst, 32'h0);
        checkOutput("rst.A.rsp_err", 32'(ifa.rsp_err), 32'd0);
        checkOutput("rst.B.req_ready", 32'(ifb.req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rel.A.req_ready_early", 32'(ifa.req_ready), 32'd0);
        tick();
        checkOutput("rel.A.req_ready", 32'(ifa.req_ready), 32'd1);
        checkOutput("rel.B.req_ready", 32'(ifb.req_ready), 32'd1);

        load(12'd0, 32'h0050_0093);
        load(12'd1, 32'h1111_1111);
        load(12'd3, 32'hAAAA_0000);

        // Basic LAT=2 fetch: accept at T, response at T+3, ready again at T+4.
        fetchA(32'h0, 1'b1);
        checkOutput("lat.T1.rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        idle(1);
        checkOutput("lat.T2.rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        idle(1);
        checkOutput("lat.T3.rsp_valid", 32'(ifa.rsp_valid), 32'd1);
        checkOutput("lat.T3.rsp_inst", ifa.rsp_inst, 32'h0050_0093);
        checkOutput("lat.T3.req_ready", 32'(ifa.req_ready), 32'd0);
        idle(1);
        checkOutput("lat.T4.req_ready", 32'(ifa.req_ready), 32'd1);
        checkOutput("lat.T4.rsp_valid", 32'(ifa.rsp_valid), 32'd0);

        // Backpressure: hold the response five cycles while a new request knocks.
        fetchA(32'h4, 1'b0);
        fetchA(32'h8, 1'b0);
        fetchA(32'h8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.rsp_inst", ifa.rsp_inst, 32'h1111_1111);
            checkOutput("bp.rsp_valid", 32'(ifa.rsp_valid), 32'd1);
            checkOutput("bp.req_ready", 32'(ifa.req_ready), 32'd0);
            fetchA(32'h8, 1'b0);
        end
        checkOutput("bp.final.rsp_valid", 32'(ifa.rsp_valid), 32'd1);
        idle(1);
        checkOutput("bp.done.rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        checkOutput("bp.done.req_ready", 32'(ifa.req_ready), 32'd1);
        idle(2);

        // Read/write collision on idx3: old word first, new word on refetch.
        fetchA(32'hC, 1'b1);
        idle(1);
        load(12'd3, 32'hBBBB_0000);
        checkOutput("col.old.rsp_inst", ifa.rsp_inst, 32'hAAAA_0000);
        idle(1);
        fetchA(32'hC, 1'b1);
        idle(2);
        checkOutput("col.new.rsp_inst", ifa.rsp_inst, 32'hBBBB_0000);
        idle(1);

        // LAT=0 instance: wrap, misalignment and a plain word.
        fetchB(32'h4000);
        checkOutput("wrap.rsp_valid", 32'(ifb.rsp_valid), 32'd1);
`ifdef IMEM_ERR_EN
        checkOutput("wrap.rsp_err", 32'(ifb.rsp_err), 32'd1);
        checkOutput("wrap.rsp_inst", ifb.rsp_inst, 32'h0000_0013);
`else
        checkOutput("wrap.rsp_err", 32'(ifb.rsp_err), 32'd0);
        checkOutput("wrap.rsp_inst", ifb.rsp_inst, 32'h0050_0093);
`endif
        idle(1);
        checkOutput("wrap.req_ready", 32'(ifb.req_ready), 32'd1);
        fetchB(32'h2);
`ifdef IMEM_ERR_EN
        checkOutput("misal.rsp_err", 32'(ifb.rsp_err), 32'd1);
`else
        checkOutput("misal.rsp_inst", ifb.rsp_inst, 32'h0050_0093);
`endif
        idle(1);
        fetchB(32'h4);
        checkOutput("b.idx1.rsp_inst", ifb.rsp_inst, 32'h1111_1111);
        checkOutput("b.idx1.rsp_err", 32'(ifb.rsp_err), 32'd0);
        idle(1);

        // Reset one cycle after accept: the fetch is dropped and a fresh one completes.
        fetchA(32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rw.busy", 32'(busy_a), 32'd0);
        checkOutput("rw.req_ready", 32'(ifa.req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            checkOutput("rw.hold.rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checkOutput("rw.after.rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        end
        fetchA(32'h0, 1'b1);
        idle(2);
        checkOutput("rw.fresh.rsp_valid", 32'(ifa.rsp_valid), 32'd1);
        checkOutput("rw.fresh.rsp_inst", ifa.rsp_inst, 32'h0050_0093);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
